arb_mux: RTL and testbench
==========================

ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter NUM_IN, default 4, number of input channels (2..16).
REQ-003 Parameter SRC_W, default 2, width of source index; SHALL equal ceil(log2(NUM_IN)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  NUM_IN  per-channel request; bit i qualifies channel i.
REQ-007 in_data  input  NUM_IN*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  NUM_IN  per-channel accept; at most one bit set per cycle.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_data  output  WIDTH  registered selected word.
REQ-011 out_src  output  SRC_W  index of channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid=1.

Function
REQ-013 Block SHALL be an N:1 arbitrated mux with a single-entry output register; transfer on a port occurs when valid and ready are both 1 at a clock edge.
REQ-014 can_accept SHALL be (!out_valid) | out_ready; in_ready SHALL be zero whenever can_accept=0.
REQ-015 When can_accept=1 and any in_valid bit set, exactly one in_ready bit (the grant) SHALL be 1, chosen by the arbitration rule; in_ready SHALL not depend on in_data.
REQ-016 On a transfer from channel g, out_data<=in_data[g], out_src<=g, out_valid<=1 at the same edge; latency input-to-output = 1 cycle.
REQ-017 If out_valid=1, out_ready=1 and no in_valid set, out_valid SHALL clear at the edge; out_data/out_src hold.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_src, out_valid SHALL remain stable.
REQ-019 Simultaneous drain and fill in one cycle SHALL sustain one word per cycle with no bubble.
REQ-020 in_valid deasserted without transfer SHALL cause no state change; no channel may be lost or duplicated.

Reset
REQ-021 While rst_n=0: out_valid=0, out_data=0, out_src=0, round-robin pointer=0, in_ready=0, independent of clk.
REQ-022 Reset asserted mid-transfer SHALL discard the held word; first grant after release follows pointer=0.

Configuration
REQ-023 Macro ARB_MUX_RR_EN defined: round-robin arbitration; grant = first set in_valid at index >= ptr, wrapping modulo NUM_IN; on each transfer ptr<=(g+1) mod NUM_IN, wrapping from NUM_IN-1 to 0.
REQ-024 Macro ARB_MUX_RR_EN undefined: fixed priority, lowest set index wins; no pointer register exists.

Structure
REQ-025 Shared package arb_mux_pkg SHALL hold default WIDTH, NUM_IN, and the index-width constant function.
REQ-026 Arbitration SHALL live in sub-module arb_mux_arbiter (requests, ptr, advance in; one-hot grant out); arb_mux holds the output register.

Verification
REQ-027 Reset: rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_src=0, in_ready=0.
REQ-028 Single channel: in_valid=4'b0100, in_data ch2=32'hDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_src=2.
REQ-029 Backpressure: out_valid=1, out_ready=0 for 5 cycles, in_valid=4'b0011 -> in_ready=0, out_data/out_src unchanged throughout.
REQ-030 RR fairness (ARB_MUX_RR_EN): in_valid=4'b1111 held, out_ready=1 -> out_src sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
REQ-031 Fixed priority (no macro): in_valid=4'b1010 held, out_ready=1 -> out_src=1 every cycle; channel 3 never granted.
REQ-032 Mid-op reset: in_valid=4'b1111 streaming, ptr=2, rst_n pulsed low between edges -> outputs zero immediately; first grant after release is channel 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared defaults and the source-index width helper for the arb_mux N:1 arbitrated mux.

package arb_mux_pkg;

   localparam int ARB_MUX_WIDTH  = 32;
   localparam int ARB_MUX_NUM_IN = 4;

   // Bits needed to index n channels, never less than one.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((32'sd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/arb_mux_arbiter.sv
// Request arbiter for arb_mux: one-hot grant plus its index.
// ARB_MUX_RR_EN selects round-robin with a pointer register; otherwise fixed lowest-index priority.

module arb_mux_arbiter
   import arb_mux_pkg::*;
#(
   parameter int NUM_IN = ARB_MUX_NUM_IN,
   parameter int SRC_W  = idx_width(ARB_MUX_NUM_IN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IN-1:0] req_i,
   input  logic              advance_i,
   output logic [NUM_IN-1:0] grant_o,
   output logic [SRC_W-1:0]  grant_idx_o
);

   logic [NUM_IN-1:0] grant_s;
   logic [SRC_W-1:0]  grant_idx_s;

`ifdef ARB_MUX_RR_EN

   logic [SRC_W-1:0] ptr_q;
   logic [SRC_W-1:0] ptr_d;

   // Pointer register: points at the channel with highest priority next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Pointer moves just past the granted channel, only when a transfer happens.
   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         if (grant_idx_s == SRC_W'(NUM_IN - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = grant_idx_s + SRC_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Search from the pointer upwards, wrapping, and take the first requester.
   always_comb begin : rr_search
      logic found;
      int   pos;
      grant_s     = '0;
      grant_idx_s = '0;
      found       = 1'b0;
      pos         = 0;
      for (int k = 0; k < NUM_IN; k++) begin
         pos = int'(ptr_q) + k;
         if (pos >= NUM_IN) begin
            pos = pos - NUM_IN;
         end else begin
            pos = pos;
         end
         if (!found && req_i[pos]) begin
            found        = 1'b1;
            grant_s[pos] = 1'b1;
            grant_idx_s  = SRC_W'(pos);
         end else begin
            found = found;
         end
      end
   end

`else

   logic unused_s;
   assign unused_s = ^{clk, rst_n, advance_i};

   // Fixed priority: scanning downwards lets the lowest set index win.
   always_comb begin
      grant_s     = '0;
      grant_idx_s = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            grant_s     = '0;
            grant_s[i]  = 1'b1;
            grant_idx_s = SRC_W'(i);
         end else begin
            grant_s = grant_s;
         end
      end
   end

`endif

   assign grant_o     = grant_s;
   assign grant_idx_o = grant_idx_s;

endmodule

// File: rtl/arb_mux.sv
// N:1 arbitrated mux with a single-entry output register (valid/ready on every port).
// Arbitration mode is chosen by the ARB_MUX_RR_EN macro (round-robin when defined, fixed priority otherwise).

module arb_mux
   import arb_mux_pkg::*;
#(
   parameter int WIDTH  = ARB_MUX_WIDTH,
   parameter int NUM_IN = ARB_MUX_NUM_IN,
   parameter int SRC_W  = idx_width(ARB_MUX_NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN-1:0]       in_valid,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [NUM_IN-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SRC_W-1:0]        out_src,
   input  logic                    out_ready
);

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SRC_W-1:0]  out_src_q,   out_src_d;

   logic              can_accept_s;
   logic              xfer_s;
   logic [NUM_IN-1:0] grant_s;
   logic [SRC_W-1:0]  grant_idx_s;
   logic [WIDTH-1:0]  sel_data_s;

   assign can_accept_s = !out_valid_q || out_ready;
   assign xfer_s       = can_accept_s && (|in_valid);

   arb_mux_arbiter #(
      .NUM_IN (NUM_IN),
      .SRC_W  (SRC_W)
   ) u_arbiter (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (in_valid),
      .advance_i   (xfer_s),
      .grant_o     (grant_s),
      .grant_idx_o (grant_idx_s)
   );

   // rst_n gates the grant so in_ready is zero during reset without waiting for a clock.
   always_comb begin
      if (rst_n && can_accept_s) begin
         in_ready = grant_s;
      end else begin
         in_ready = '0;
      end
   end

   // One-hot grant selects the word; independent of the grant index encoding.
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_s[i]) begin
            sel_data_s = sel_data_s | in_data[i*WIDTH +: WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // Output register next state: fill (possibly while draining), drain, or hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      if (xfer_s) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data_s;
         out_src_d   = grant_idx_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Output register state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios followed by randomized traffic
// compared against a transaction-level model of the arbitration and output register.

module tb_arb_mux;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_src;
   logic           out_ready;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model state: the word the output register should hold and the arbitration pointer.
   bit         m_valid;
   logic [W-1:0] m_data;
   int         m_src;
   int         m_ptr;

   arb_mux #(.WIDTH(W), .NUM_IN(N), .SRC_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v, input int ptr);
`ifdef ARB_MUX_RR_EN
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (v[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic logic [N-1:0] model_ready();
      int g;
      logic [N-1:0] one;
      one = 4'b0001;
      g = model_grant(in_valid, m_ptr);
      if (rst_n !== 1'b1) return '0;
      if ((!m_valid || out_ready) && g >= 0) return one << g;
      return '0;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_ptr   = 0;
   endtask

   task automatic model_edge();
      int g;
      g = model_grant(in_valid, m_ptr);
      if ((!m_valid || out_ready) && g >= 0) begin
         m_valid = 1'b1;
         m_data  = in_data[g*W +: W];
         m_src   = g;
`ifdef ARB_MUX_RR_EN
         m_ptr   = (g + 1) % N;
`endif
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_in_ready"},  32'(in_ready),  32'(model_ready()));
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
      check_eq({tag, "_out_data"},  out_data,       m_data);
      check_eq({tag, "_out_src"},   32'(out_src),   32'(m_src));
   endtask

   function automatic logic [N*W-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Apply inputs just after an edge, check mid-cycle, then advance the model across the edge.
   task automatic drive_cycle(input string tag, input logic [N-1:0] v, input logic r,
                              input logic [N*W-1:0] d);
      in_valid  = v;
      out_ready = r;
      in_data   = d;
      #3;
      check_outputs(tag);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [N*W-1:0] d;
      int guard;

      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      in_data   = rand_data();
      model_reset();
      #12;
      check_outputs("reset");

      in_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single channel 2 transfer with one-cycle latency.
      d = rand_data();
      d[2*W +: W] = 32'hDEAD_BEEF;
      drive_cycle("single", 4'b0100, 1'b1, d);
      check_eq("single_valid", 32'(out_valid), 32'd1);
      check_eq("single_data",  out_data,       32'hDEAD_BEEF);
      check_eq("single_src",   32'(out_src),   32'd2);

      // Backpressure: held word must stay put and no channel may be accepted.
      for (int i = 0; i < 5; i++) begin
         drive_cycle("bp", 4'b0011, 1'b0, rand_data());
         check_eq("bp_in_ready", 32'(in_ready), 32'd0);
         check_eq("bp_data",     out_data,      32'hDEAD_BEEF);
         check_eq("bp_src",      32'(out_src),  32'd2);
      end

      // Saturated streaming: one word every cycle.
      for (int i = 0; i < 8; i++) begin
`ifdef ARB_MUX_RR_EN
         drive_cycle("rr", 4'b1111, 1'b1, rand_data());
`else
         drive_cycle("fp", 4'b1010, 1'b1, rand_data());
         check_eq("fp_src", 32'(out_src), 32'd1);
`endif
         check_eq("stream_valid", 32'(out_valid), 32'd1);
      end

      // Stream until the pointer sits at 2 (bounded), then reset between edges.
      guard = 0;
      do begin
         drive_cycle("pre_rst", 4'b1111, 1'b1, rand_data());
         guard++;
`ifdef ARB_MUX_RR_EN
      end while (m_ptr != 2 && guard < 8);
      check_eq("pre_rst_ptr_reached", 32'(m_ptr), 32'd2);
`else
      end while (guard < 2);
`endif
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("mid_rst");
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      check_outputs("mid_rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle("post_rst", 4'b1111, 1'b1, rand_data());
      check_eq("post_rst_src", 32'(out_src), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive_cycle("rand", 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rand_data());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
